// File: rtl/alu_operand_regfile.sv
// rtl/alu_operand_regfile.sv - 8x16 register file feeding ALU operands A and B
module alu_operand_regfile #(
  parameter int WIDTH     = 16,
  parameter int NUM_REGS  = 8,
  parameter int IMM_WIDTH = 5
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        LD_REG,
  input  logic [$clog2(NUM_REGS)-1:0] DR,
  input  logic [WIDTH-1:0]            BUS,
  input  logic [$clog2(NUM_REGS)-1:0] SR1,
  input  logic [$clog2(NUM_REGS)-1:0] SR2,
  input  logic                        SR2MUX,
  input  logic [IMM_WIDTH-1:0]        IMM,
  output logic [WIDTH-1:0]            A,
  output logic [WIDTH-1:0]            B
);

  logic [WIDTH-1:0] regs [NUM_REGS];
  logic [WIDTH-1:0] imm_ext;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (LD_REG) begin
      regs[DR] <= BUS;
    end
  end

  // Reads come straight from storage, so a same-cycle write is not forwarded.
  assign imm_ext = {{(WIDTH-IMM_WIDTH){IMM[IMM_WIDTH-1]}}, IMM};
  assign A       = regs[SR1];
  assign B       = SR2MUX ? imm_ext : regs[SR2];

endmodule

// File: tb/tb_alu_operand_regfile.sv
// tb/tb_alu_operand_regfile.sv - directed self-checking bench for alu_operand_regfile
module tb_alu_operand_regfile;

  logic        clk;
  logic        reset;
  logic        ld_reg;
  logic [2:0]  dr;
  logic [15:0] bus;
  logic [2:0]  sr1;
  logic [2:0]  sr2;
  logic        sr2mux;
  logic [4:0]  imm;
  logic [15:0] a;
  logic [15:0] b;

  int checks = 0;
  int errors = 0;

  alu_operand_regfile dut (
    .Clk    (clk),
    .Reset  (reset),
    .LD_REG (ld_reg),
    .DR     (dr),
    .BUS    (bus),
    .SR1    (sr1),
    .SR2    (sr2),
    .SR2MUX (sr2mux),
    .IMM    (imm),
    .A      (a),
    .B      (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [2:0] idx, input logic [15:0] val);
    ld_reg = 1'b1;
    dr     = idx;
    bus    = val;
    tick();
    ld_reg = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_v;

    reset  = 1'b1;
    ld_reg = 1'b0;
    dr     = '0;
    bus    = '0;
    sr1    = '0;
    sr2    = '0;
    sr2mux = 1'b0;
    imm    = '0;
    tick();
    tick();
    reset = 1'b0;

    // Initial reset leaves every register zero
    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i);
      sr2 = 3'(i);
      #1;
      check($sformatf("init_a_r%0d", i), a, 16'h0000);
      check($sformatf("init_b_r%0d", i), b, 16'h0000);
    end

    // Reset clear after a write
    write_reg(3'd3, 16'hBEEF);
    sr1 = 3'd3;
    #1;
    check("pre_reset_r3", a, 16'hBEEF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i);
      #1;
      check($sformatf("reset_clear_r%0d", i), a, 16'h0000);
    end

    // Write all, read through both ports with IMM driven as a distractor
    for (int i = 0; i < 8; i++) begin
      write_reg(3'(i), 16'(16'h1111 * i));
    end
    sr2mux = 1'b0;
    imm    = 5'b10101;
    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i);
      sr2 = 3'(7 - i);
      #1;
      check($sformatf("wr_all_a_r%0d", i), a, 16'(16'h1111 * i));
      check($sformatf("wr_all_b_r%0d", 7 - i), b, 16'(16'h1111 * (7 - i)));
    end

    // Same index on both ports
    sr1 = 3'd6;
    sr2 = 3'd6;
    #1;
    check("same_idx_a", a, 16'h6666);
    check("same_idx_b", b, 16'h6666);

    // No-bypass timing on R2
    write_reg(3'd2, 16'h0005);
    sr1    = 3'd2;
    sr2    = 3'd2;
    dr     = 3'd2;
    bus    = 16'h00A0;
    ld_reg = 1'b1;
    #1;
    check("nobypass_a_before", a, 16'h0005);
    check("nobypass_b_before", b, 16'h0005);
    tick();
    ld_reg = 1'b0;
    check("nobypass_a_after", a, 16'h00A0);
    check("nobypass_b_after", b, 16'h00A0);
    sr1 = 3'd3;
    #1;
    check("neighbor_r3_kept", a, 16'h3333);

    // Reset has priority over a write in the same cycle
    reset  = 1'b1;
    ld_reg = 1'b1;
    dr     = 3'd4;
    bus    = 16'h1234;
    tick();
    reset  = 1'b0;
    ld_reg = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i);
      #1;
      check($sformatf("reset_prio_r%0d", i), a, 16'h0000);
    end

    // Immediate sign extension with R5 holding a distinct pattern
    write_reg(3'd5, 16'hAAAA);
    sr2    = 3'd5;
    sr2mux = 1'b0;
    #1;
    check("imm_sel_reg", b, 16'hAAAA);
    sr2mux = 1'b1;
    imm = 5'b01111; #1; check("imm_01111", b, 16'h000F);
    imm = 5'b10000; #1; check("imm_10000", b, 16'hFFF0);
    imm = 5'b11111; #1; check("imm_11111", b, 16'hFFFF);
    imm = 5'b00000; #1; check("imm_00000", b, 16'h0000);
    imm = 5'b00101; #1; check("imm_00101", b, 16'h0005);
    imm = 5'b11010; #1; check("imm_11010", b, 16'hFFFA);
    sr2 = 3'd0;
    imm = 5'b00001; #1; check("imm_sr2_ignored", b, 16'h0001);
    sr2mux = 1'b0;

    // Hold with LD_REG low and a live-looking BUS
    write_reg(3'd1, 16'h0042);
    write_reg(3'd7, 16'h7007);
    ld_reg = 1'b0;
    dr     = 3'd1;
    bus    = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      tick();
    end
    sr1 = 3'd1;
    sr2 = 3'd7;
    #1;
    check("hold_r1", a, 16'h0042);
    check("hold_r7", b, 16'h7007);
    sr1 = 3'd5;
    #1;
    check("hold_r5", a, 16'hAAAA);

    // Walking-ones write into R0 then readback through both ports
    for (int k = 0; k < 16; k += 5) begin
      exp_v = 16'(1) << k;
      write_reg(3'd0, exp_v);
      sr1 = 3'd0;
      sr2 = 3'd0;
      #1;
      check($sformatf("walk_a_bit%0d", k), a, exp_v);
      check($sformatf("walk_b_bit%0d", k), b, exp_v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
